// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the serial pattern generator.
package seq_gen_pkg;

    localparam int MAX_LEN = 8;
    localparam int CW      = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        FINISH
    } state_t;

endpackage

// File: rtl/seq_gen.sv
// Serial pattern generator: emits Pattern[Len-1:0] MSB first, Reps times,
// with Gap idle cycles between repetitions, then pulses Done.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = seq_gen_pkg::MAX_LEN,
    parameter int CW      = seq_gen_pkg::CW
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [MAX_LEN-1:0] Pattern,
    input  logic [CW-1:0]      Len,
    input  logic [CW-1:0]      Reps,
    input  logic [CW-1:0]      Gap,
    output logic               B,
    output logic               Valid,
    output logic               Busy,
    output logic               Done
);

    localparam int LW = $clog2(MAX_LEN + 1);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] sr_q, sr_d;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      bit_q, bit_d;
    logic [CW-1:0]      reps_q, reps_d;
    logic [CW-1:0]      gap_q, gap_d;
    logic [CW-1:0]      gcnt_q, gcnt_d;
    logic               b_q, b_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [LW-1:0]      eff_len;
    logic [MAX_LEN-1:0] aligned_in;

    // The pattern is stored left-aligned so the current bit is always the MSB.
    always_comb begin
        if (int'(Len) > MAX_LEN) begin
            eff_len = LW'(MAX_LEN);
        end else begin
            eff_len = LW'(Len);
        end
        aligned_in = Pattern << (LW'(MAX_LEN) - eff_len);
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sr_d    = sr_q;
        len_d   = len_q;
        bit_d   = bit_q;
        reps_d  = reps_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        b_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    pat_d  = aligned_in;
                    len_d  = eff_len;
                    reps_d = (Reps == '0) ? CW'(1) : Reps;
                    gap_d  = Gap;
                    gcnt_d = '0;
                    if (eff_len == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        b_d     = aligned_in[MAX_LEN-1];
                        sr_d    = aligned_in << 1;
                        bit_d   = eff_len;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end

            // bit_q holds how many bits of this repetition remain, including the one on B.
            SHIFT: begin
                if (bit_q > LW'(1)) begin
                    bit_d   = bit_q - LW'(1);
                    b_d     = sr_q[MAX_LEN-1];
                    sr_d    = sr_q << 1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (reps_q > CW'(1)) begin
                    reps_d = reps_q - CW'(1);
                    busy_d = 1'b1;
                    if (gap_q != '0) begin
                        state_d = GAP;
                        gcnt_d  = gap_q;
                    end else begin
                        b_d     = pat_q[MAX_LEN-1];
                        sr_d    = pat_q << 1;
                        bit_d   = len_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    state_d = FINISH;
                    bit_d   = '0;
                    done_d  = 1'b1;
                end
            end

            GAP: begin
                busy_d = 1'b1;
                if (gcnt_q > CW'(1)) begin
                    gcnt_d = gcnt_q - CW'(1);
                end else begin
                    gcnt_d  = '0;
                    state_d = SHIFT;
                    b_d     = pat_q[MAX_LEN-1];
                    sr_d    = pat_q << 1;
                    bit_d   = len_q;
                    valid_d = 1'b1;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            sr_q    <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            reps_q  <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            b_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sr_q    <= sr_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            reps_q  <= reps_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign B     = b_q;
    assign Valid = valid_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: a cycle-level expectation queue plus
// hand-computed literal streams for the key scenarios.
module tb_seq_gen;

    localparam int MAX_LEN = 8;
    localparam int CW      = 4;

    logic               Clk;
    logic               Rst;
    logic               Start;
    logic [MAX_LEN-1:0] Pattern;
    logic [CW-1:0]      Len;
    logic [CW-1:0]      Reps;
    logic [CW-1:0]      Gap;
    logic               B;
    logic               Valid;
    logic               Busy;
    logic               Done;

    int tests = 0;
    int fails = 0;

    logic [3:0] expQ[$];
    logic       inFinish = 1'b0;

    seq_gen #(.MAX_LEN(MAX_LEN), .CW(CW)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (Start),
        .Pattern (Pattern),
        .Len     (Len),
        .Reps    (Reps),
        .Gap     (Gap),
        .B       (B),
        .Valid   (Valid),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: on an accepted Start, the whole future output sequence {B,Valid,Busy,Done} is queued.
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            expQ.delete();
        end else if (expQ.size() == 0 && !inFinish && Start) begin
            int effLen;
            int effReps;
            effLen  = (int'(Len) > MAX_LEN) ? MAX_LEN : int'(Len);
            effReps = (Reps == 0) ? 1 : int'(Reps);
            for (int r = 0; r < effReps && effLen > 0; r++) begin
                for (int i = 0; i < effLen; i++) begin
                    expQ.push_back({Pattern[effLen-1-i], 3'b110});
                end
                if (r < effReps - 1) begin
                    for (int g = 0; g < int'(Gap); g++) begin
                        expQ.push_back(4'b0010);
                    end
                end
            end
            expQ.push_back(4'b0001);
        end
    end

    always @(negedge Clk) begin
        logic [3:0] e;
        if (!Rst) begin
            e        = 4'b0000;
            inFinish = 1'b0;
        end else begin
            e        = (expQ.size() > 0) ? expQ.pop_front() : 4'b0000;
            inFinish = e[0];
        end
        check("model", {28'd0, B, Valid, Busy, Done}, {28'd0, e});
    end

    task automatic applyStimulus(input logic [MAX_LEN-1:0] pat, input logic [CW-1:0] len,
                                 input logic [CW-1:0] reps, input logic [CW-1:0] gap);
        @(negedge Clk);
        Pattern = pat;
        Len     = len;
        Reps    = reps;
        Gap     = gap;
        Start   = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    // Captures w cycles after acceptance, MSB of the literal = cycle 1.
    task automatic checkOutput(input string name, input int w, input logic [15:0] expB,
                               input logic [15:0] expV, input int expDone, input int repulseAt);
        logic [15:0] gotB;
        logic [15:0] gotV;
        int          firstDone;
        int          doneCount;
        gotB      = '0;
        gotV      = '0;
        firstDone = 0;
        doneCount = 0;
        for (int c = 1; c <= w; c++) begin
            @(negedge Clk);
            gotB = {gotB[14:0], B};
            gotV = {gotV[14:0], Valid};
            if (Done) begin
                doneCount++;
                if (firstDone == 0) firstDone = c;
            end
            if (c == repulseAt) begin
                Pattern = ~Pattern;
                Start   = 1'b1;
            end else begin
                Start = 1'b0;
            end
        end
        Start = 1'b0;
        check({name, ".bits"},  {16'd0, gotB}, {16'd0, expB});
        check({name, ".valid"}, {16'd0, gotV}, {16'd0, expV});
        check({name, ".doneAt"}, firstDone, expDone);
        check({name, ".doneCnt"}, doneCount, 1);
    endtask

    initial begin
        Start   = 1'b0;
        Pattern = '0;
        Len     = '0;
        Reps    = '0;
        Gap     = '0;
        Rst     = 1'b1;
        #2 Rst  = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset", {28'd0, B, Valid, Busy, Done}, 32'd0);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        check("idle", {28'd0, B, Valid, Busy, Done}, 32'd0);

        applyStimulus(8'b110, 4'd3, 4'd1, 4'd0);
        checkOutput("single", 6, 16'b110000, 16'b111000, 4, 0);

        applyStimulus(8'b101, 4'd3, 4'd2, 4'd2);
        checkOutput("gap", 11, 16'b10100101000, 16'b11100111000, 9, 0);

        applyStimulus(8'b011, 4'd3, 4'd1, 4'd0);
        checkOutput("repulse", 6, 16'b011000, 16'b111000, 4, 1);

        applyStimulus(8'b1111_1111, 4'd0, 4'd2, 4'd1);
        checkOutput("len0", 3, 16'b000, 16'b000, 1, 0);

        applyStimulus(8'b1011_0011, 4'd12, 4'd1, 4'd0);
        checkOutput("clamp", 11, 16'b10110011000, 16'b11111111000, 9, 0);

        applyStimulus(8'b10, 4'd2, 4'd0, 4'd3);
        checkOutput("reps0", 5, 16'b10000, 16'b11000, 3, 0);

        applyStimulus(8'b01, 4'd2, 4'd3, 4'd0);
        checkOutput("back2back", 9, 16'b010101000, 16'b111111000, 7, 0);

        applyStimulus(8'b101, 4'd3, 4'd2, 4'd2);
        @(negedge Clk);
        check("abort.c1", {30'd0, B, Valid}, 32'b11);
        @(posedge Clk);
        #2 Rst = 1'b0;
        #1 check("abort.imm", {28'd0, B, Valid, Busy, Done}, 32'd0);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        applyStimulus(8'b101, 4'd3, 4'd2, 4'd2);
        checkOutput("afterRst", 11, 16'b10100101000, 16'b11100111000, 9, 0);

        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
